ctrl_word_sequencer: RTL and testbench
======================================

// Module: ctrl_word_sequencer
// PURPOSE
// - Programmable control-word sequencer for CPU_TOP_MODULE: replays a stored list of control
//   vectors (RegWrite..MemToReg) onto the datapath control inputs, one entry per step.
// - Each entry holds for a programmable number of cycles; the sequence runs once or loops.
// - Sits between a host/loader and the datapath control pins, so no hand-written control drive is needed.
// PARAMETERS
// - CW_W    23  control word width (field layout fixed in ctrl_pkg)
// - DEPTH   16  number of sequence entries; AW = $clog2(DEPTH)
// - HOLD_W  4   hold-count width; an entry is presented for hold+1 cycles
// PORTS
// - clk       in   1       system clock, rising edge
// - rst       in   1       asynchronous, active-high reset
// - wr_en     in   1       write one entry this cycle
// - wr_addr   in   AW      entry index to write
// - wr_cw     in   CW_W    control word to store
// - wr_hold   in   HOLD_W  extra hold cycles for the entry
// - start     in   1       begin the sequence at entry 0 (sampled in IDLE/DONE)
// - stop      in   1       abort the sequence, return to IDLE
// - loop_en   in   1       after last_idx, wrap to entry 0 instead of finishing
// - last_idx  in   AW      index of final entry (0..DEPTH-1)
// - cw_out    out  CW_W    control word driven to datapath; all-zero = NOP
// - cw_valid  out  1       cw_out is a sequence entry
// - step_idx  out  AW      index of the entry currently on cw_out
// - busy      out  1       state == RUN
// - done      out  1       state == DONE (held until next start or stop)
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE; cw_out=0, cw_valid=0, step_idx=0, busy=0, done=0, hold counter=0.
//   Entry storage is not reset; contents are undefined until written.
// - States: IDLE -> RUN on start; RUN -> DONE at end of last_idx (loop_en=0); RUN -> RUN wrap (loop_en=1);
//   RUN/DONE -> IDLE on stop; DONE -> RUN on start.
// - All outputs registered. Edge sampling start in IDLE/DONE: cw_out<=mem[0], cnt<=hold[0],
//   step_idx<=0, cw_valid<=1. Latency start -> first word = 1 cycle.
// - In RUN each edge: cnt!=0 -> cnt-1, outputs held; cnt==0 -> advance: next=step_idx+1
//   (or 0 on wrap), cw_out<=mem[next], cnt<=hold[next]. Entry i is visible exactly hold[i]+1 cycles.
// - Entering DONE or IDLE: cw_out<=0, cw_valid<=0 on the same edge; step_idx retains last value.
// - stop and start on the same edge: stop wins. start while in RUN: ignored. stop in IDLE: no-op.
// - Writes: accepted in any state, take effect on the edge. A write to the entry being presented does
//   not change cw_out; it is used the next time that entry is fetched. Write to wr_addr >= DEPTH ignored.
// - Write and fetch of the same entry on the same edge: fetch returns the OLD contents.
// - last_idx, loop_en are sampled at each advance decision; last_idx >= DEPTH is treated as DEPTH-1.
// - Hold counter is HOLD_W bits, no wrap: hold=2^HOLD_W-1 gives 2^HOLD_W cycles.
// STRUCTURE
// - ctrl_pkg: CW_W; field offsets/widths: [0]RegWrite [1]ImmSel [2]ALUSrc [3]CompEnbl [4]ShiftAmntSel
//   [5]ShiftEnbl [6]ShortBr [7]LongBr [8]MemRead [9]MemWrite [10]BranchReg [12:11]ALUOp [14:13]RegDst
//   [16:15]ShiftType [18:17]BranchType [20:19]JumpType [22:21]MemToReg; state encodings IDLE/RUN/DONE;
//   ALUOp codes (01 add, 10 and, 11 xor).
// - Sub-module ctrl_word_mem: DEPTH x (CW_W+HOLD_W) register array, 1 sync write port, 1 async read port.
// - Top: FSM, hold counter, index logic, output registers, field unpack to named control pins.
// TESTING
// - Reset mid-RUN at entry 2 -> all outputs 0 within the same cycle; after release, stays IDLE until start.
// - Load e0={addi,ALUOp=01,ALUSrc=1,RegWrite=1,hold=3}, e1={compi,CompEnbl=1,hold=0}, last_idx=1,
//   loop_en=0, start -> e0 for 4 cycles, e1 for 1 cycle, then cw_out=0, done=1, busy=0.
// - 9-entry arithmetic program (addi/compi/add/comp/and/xor, all hold=0) on CPU_TOP_MODULE -> r0..r5
//   match the hand-driven control sequence results cycle for cycle.
// - loop_en=1, last_idx=2, holds {1,0,0} -> step_idx pattern 0,0,1,2,0,0,1,2... for 3 loops; stop -> IDLE next edge.
// - start and stop on the same edge in IDLE -> remains IDLE, cw_valid=0; start during RUN -> no restart.
// - Write e1 while e1 is presented (hold=5) -> cw_out unchanged for remaining cycles; next loop shows new word.

Source files
------------

// File: rtl/ctrl_word_sequencer_pkg.sv
// Shared definitions for the control-word sequencer.
// Contents: geometry constants, FSM state type, control-word field layout
// and a helper that unpacks a raw control word into named fields.
package ctrl_word_sequencer_pkg;

  localparam int CW_W    = 23;
  localparam int DEPTH   = 16;
  localparam int AW      = $clog2(DEPTH);
  localparam int HOLD_W  = 4;
  localparam int ENTRY_W = CW_W + HOLD_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seqState_t;

  localparam logic [1:0] ALUOP_ADD = 2'b01;
  localparam logic [1:0] ALUOP_AND = 2'b10;
  localparam logic [1:0] ALUOP_XOR = 2'b11;

  // Declared MSB first so the struct overlays the raw word bit-for-bit.
  typedef struct packed {
    logic [1:0] memToReg;     // [22:21]
    logic [1:0] jumpType;     // [20:19]
    logic [1:0] branchType;   // [18:17]
    logic [1:0] shiftType;    // [16:15]
    logic [1:0] regDst;       // [14:13]
    logic [1:0] aluOp;        // [12:11]
    logic       branchReg;    // [10]
    logic       memWrite;     // [9]
    logic       memRead;      // [8]
    logic       longBr;       // [7]
    logic       shortBr;      // [6]
    logic       shiftEnbl;    // [5]
    logic       shiftAmntSel; // [4]
    logic       compEnbl;     // [3]
    logic       aluSrc;       // [2]
    logic       immSel;       // [1]
    logic       regWrite;     // [0]
  } ctrlFields_t;

  function automatic ctrlFields_t unpackCw(input logic [CW_W-1:0] cw);
    return ctrlFields_t'(cw);
  endfunction

endpackage

// File: rtl/ctrl_word_sequencer_if.sv
// Host/datapath bundle for the control-word sequencer.
// master: loader/host side (drives writes and run control, observes status).
// slave : sequencer side (drives cw_out, named control fields and status).
interface ctrl_word_sequencer_if;
  import ctrl_word_sequencer_pkg::*;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [CW_W-1:0]   wr_cw;
  logic [HOLD_W-1:0] wr_hold;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [AW-1:0]     last_idx;
  logic [CW_W-1:0]   cw_out;
  logic              cw_valid;
  logic [AW-1:0]     step_idx;
  logic              busy;
  logic              done;
  ctrlFields_t       ctrl;

  modport master (
    output wr_en, wr_addr, wr_cw, wr_hold, start, stop, loop_en, last_idx,
    input  cw_out, cw_valid, step_idx, busy, done, ctrl
  );

  modport slave (
    input  wr_en, wr_addr, wr_cw, wr_hold, start, stop, loop_en, last_idx,
    output cw_out, cw_valid, step_idx, busy, done, ctrl
  );

endinterface

// File: rtl/ctrl_word_sequencer_mem.sv
// Entry storage: DEPTH x {hold, cw} registers, one synchronous write port,
// one asynchronous read port. Not reset; contents are undefined until written.
// Ports: clk, wrEn/wrAddr/wrData (write), rdAddr/rdData (combinational read).
module ctrl_word_sequencer_mem
  import ctrl_word_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               wrEn,
  input  logic [AW-1:0]      wrAddr,
  input  logic [ENTRY_W-1:0] wrData,
  input  logic [AW-1:0]      rdAddr,
  output logic [ENTRY_W-1:0] rdData
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic               wrInRange;

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  if (DEPTH == (1 << AW)) begin : gFullDecode
    assign wrInRange = 1'b1;
  end else begin : gPartialDecode
    assign wrInRange = (wrAddr < AW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (wrEn && wrInRange) mem[wrAddr] <= wrData;
  end

  // Read sees the pre-edge contents, so a same-edge write/fetch returns old data.
  assign rdData = mem[rdAddr];

endmodule

// File: rtl/ctrl_word_sequencer.sv
// Control-word sequencer: replays stored control words onto the datapath,
// each held for hold+1 cycles, once or looping.
// Ports: clk, rst (async, active high), bus (ctrl_word_sequencer_if.slave).
//
// state | meaning
// IDLE  | no sequence, cw_out = 0
// RUN   | presenting entry step_idx, holdCnt cycles left after this one
// DONE  | sequence finished, cw_out = 0, waiting for start or stop
module ctrl_word_sequencer
  import ctrl_word_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  ctrl_word_sequencer_if.slave bus
);

  seqState_t          state, stateNext;
  logic [CW_W-1:0]    cwOut, cwNext;
  logic               cwValid, validNext;
  logic [AW-1:0]      stepIdx, idxNext;
  logic [HOLD_W-1:0]  holdCnt, cntNext;
  logic [AW-1:0]      rdAddr, lastIdx, advIdx;
  logic [ENTRY_W-1:0] rdData;
  logic               atLast;

  ctrl_word_sequencer_mem uMem (
    .clk    (clk),
    .wrEn   (bus.wr_en),
    .wrAddr (bus.wr_addr),
    .wrData ({bus.wr_hold, bus.wr_cw}),
    .rdAddr (rdAddr),
    .rdData (rdData)
  );

  if (DEPTH == (1 << AW)) begin : gLastFull
    assign lastIdx = bus.last_idx;
  end else begin : gLastClamp
    assign lastIdx = (bus.last_idx >= AW'(DEPTH)) ? AW'(DEPTH - 1) : bus.last_idx;
  end

  // >= keeps the sequence bounded if last_idx is lowered below the current step.
  assign atLast = (stepIdx >= lastIdx);
  assign advIdx = atLast ? '0 : stepIdx + AW'(1);
  assign rdAddr = (state == RUN) ? advIdx : '0;

  always_comb begin
    stateNext = state;
    cwNext    = cwOut;
    validNext = cwValid;
    idxNext   = stepIdx;
    cntNext   = holdCnt;
    case (state)
      IDLE, DONE: begin
        if (bus.stop) begin
          stateNext = IDLE;
          cwNext    = '0;
          validNext = 1'b0;
          cntNext   = '0;
        end else if (bus.start) begin
          stateNext = RUN;
          cwNext    = rdData[CW_W-1:0];
          cntNext   = rdData[ENTRY_W-1:CW_W];
          idxNext   = '0;
          validNext = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          stateNext = IDLE;
          cwNext    = '0;
          validNext = 1'b0;
          cntNext   = '0;
        end else if (holdCnt != '0) begin
          cntNext = holdCnt - HOLD_W'(1);
        end else if (atLast && !bus.loop_en) begin
          stateNext = DONE;
          cwNext    = '0;
          validNext = 1'b0;
        end else begin
          cwNext    = rdData[CW_W-1:0];
          cntNext   = rdData[ENTRY_W-1:CW_W];
          idxNext   = advIdx;
          validNext = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        cwNext    = '0;
        validNext = 1'b0;
        cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cwOut   <= '0;
      cwValid <= 1'b0;
      stepIdx <= '0;
      holdCnt <= '0;
    end else begin
      state   <= stateNext;
      cwOut   <= cwNext;
      cwValid <= validNext;
      stepIdx <= idxNext;
      holdCnt <= cntNext;
    end
  end

  assign bus.cw_out   = cwOut;
  assign bus.cw_valid = cwValid;
  assign bus.step_idx = stepIdx;
  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.ctrl     = unpackCw(cwOut);

endmodule

// File: tb/tb_ctrl_word_sequencer.sv
// Self-checking bench for ctrl_word_sequencer. The reference model expands
// the stored program into a per-cycle timeline of (index, word) pairs.
module tb_ctrl_word_sequencer;
  import ctrl_word_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  ctrl_word_sequencer_if bus();

  ctrl_word_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [CW_W-1:0] mCw [DEPTH];
  int              mHold [DEPTH];
  int              expIdx [$];
  logic [CW_W-1:0] expCw [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic writeEntry(input int a, input logic [CW_W-1:0] cw, input int h);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a[AW-1:0];
    bus.wr_cw   = cw;
    bus.wr_hold = h[HOLD_W-1:0];
    tick();
    bus.wr_en = 1'b0;
    mCw[a]    = cw;
    mHold[a]  = h;
  endtask

  function automatic logic [CW_W-1:0] randCw();
    logic [31:0] r;
    r = $urandom;
    return r[CW_W-1:0];
  endfunction

  // Each entry i contributes hold[i]+1 consecutive cycles, passes times over.
  task automatic buildTimeline(input int last, input int passes);
    expIdx.delete();
    expCw.delete();
    for (int p = 0; p < passes; p++)
      for (int i = 0; i <= last; i++)
        for (int k = 0; k <= mHold[i]; k++) begin
          expIdx.push_back(i);
          expCw.push_back(mCw[i]);
        end
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Walks the timeline; optionally raises start, or writes an entry, at one step.
  task automatic runTimeline(input string tag, input int startAt, input int writeAt,
                             input int wAddr, input logic [CW_W-1:0] wCw);
    logic [CW_W-1:0] e;
    for (int i = 0; i < expIdx.size(); i++) begin
      e = expCw[i];
      check({tag, "_cw"},    32'(bus.cw_out),   32'(e));
      check({tag, "_idx"},   32'(bus.step_idx), expIdx[i]);
      check({tag, "_valid"}, 32'(bus.cw_valid), 1);
      check({tag, "_busy"},  32'(bus.busy),     1);
      check({tag, "_aluop"}, 32'(bus.ctrl.aluOp), 32'(e[12:11]));
      if (i == startAt) bus.start = 1'b1;
      if (i == writeAt) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = wAddr[AW-1:0];
        bus.wr_cw   = wCw;
        bus.wr_hold = mHold[wAddr][HOLD_W-1:0];
      end
      tick();
      bus.start = 1'b0;
      if (i == writeAt) begin
        bus.wr_en  = 1'b0;
        mCw[wAddr] = wCw;
      end
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_cw"},    32'(bus.cw_out),   0);
    check({tag, "_valid"}, 32'(bus.cw_valid), 0);
    check({tag, "_busy"},  32'(bus.busy),     0);
    check({tag, "_done"},  32'(bus.done),     0);
  endtask

  task automatic checkDone(input string tag, input int last);
    check({tag, "_cw"},    32'(bus.cw_out),   0);
    check({tag, "_valid"}, 32'(bus.cw_valid), 0);
    check({tag, "_busy"},  32'(bus.busy),     0);
    check({tag, "_done"},  32'(bus.done),     1);
    check({tag, "_idx"},   32'(bus.step_idx), last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    int n;
    logic [CW_W-1:0] newCw;

    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_cw = '0; bus.wr_hold = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0; bus.last_idx = '0;
    tick(); tick();
    checkIdle("reset");
    check("reset_idx", 32'(bus.step_idx), 0);
    rst = 1'b0;
    tick();

    // Directed two-entry program: addi (hold 3) then compi (hold 0).
    writeEntry(0, 23'h000805, 3);
    writeEntry(1, 23'h000008, 0);
    bus.last_idx = 4'd1;
    bus.loop_en  = 1'b0;
    buildTimeline(1, 1);
    pulseStart();
    check("addi_regwrite", 32'(bus.ctrl.regWrite), 1);
    check("addi_alusrc",   32'(bus.ctrl.aluSrc),   1);
    check("addi_aluop",    32'(bus.ctrl.aluOp),    32'(ALUOP_ADD));
    runTimeline("dir", -1, -1, 0, '0);
    checkDone("dir_done", 1);

    // Random programs; a start raised mid-run must not restart.
    for (int r = 0; r < 3; r++) begin
      last = $urandom_range(2, 7);
      for (int i = 0; i <= last; i++) writeEntry(i, randCw(), $urandom_range(0, 3));
      bus.last_idx = last[AW-1:0];
      buildTimeline(last, 1);
      pulseStart();
      runTimeline("rnd", 3, -1, 0, '0);
      checkDone("rnd_done", last);
    end

    // Maximum hold: one entry visible for 2^HOLD_W cycles.
    writeEntry(0, randCw(), 15);
    bus.last_idx = 4'd0;
    buildTimeline(0, 1);
    check("maxhold_len", expIdx.size(), 16);
    pulseStart();
    runTimeline("maxhold", -1, -1, 0, '0);
    checkDone("maxhold_done", 0);

    // Looping: holds {1,0,0} give indices 0,0,1,2 repeating.
    writeEntry(0, randCw(), 1);
    writeEntry(1, randCw(), 0);
    writeEntry(2, randCw(), 0);
    bus.last_idx = 4'd2;
    bus.loop_en  = 1'b1;
    buildTimeline(2, 3);
    pulseStart();
    runTimeline("loop", -1, -1, 0, '0);
    check("loop_wrap_idx",   32'(bus.step_idx), 0);
    check("loop_wrap_valid", 32'(bus.cw_valid), 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    checkIdle("loop_stop");
    check("loop_stop_idx", 32'(bus.step_idx), 0);

    // start and stop together in IDLE: stop wins.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    checkIdle("startstop");
    tick();
    checkIdle("startstop_hold");

    // Rewrite e1 while it is on cw_out: current presentation unchanged, next loop uses new word.
    writeEntry(0, randCw(), 0);
    writeEntry(1, randCw(), 5);
    bus.last_idx = 4'd1;
    bus.loop_en  = 1'b1;
    buildTimeline(1, 1);
    newCw = randCw() ^ mCw[1];
    if (newCw == mCw[1]) newCw = ~newCw;
    pulseStart();
    runTimeline("wr_live", -1, 2, 1, newCw);
    buildTimeline(1, 2);
    runTimeline("wr_next", -1, -1, 0, '0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    checkIdle("wr_stop");

    // Asynchronous reset while presenting entry 2.
    for (int i = 0; i < 5; i++) writeEntry(i, randCw() | 23'h1, 1);
    bus.last_idx = 4'd4;
    bus.loop_en  = 1'b0;
    pulseStart();
    n = 0;
    while (bus.step_idx != 4'd2 && n < 50) begin
      tick();
      n++;
    end
    check("rst_reach_e2", 32'(n < 50), 1);
    check("rst_pre_valid", 32'(bus.cw_valid), 1);
    #1 rst = 1'b1;
    #1;
    checkIdle("rst_async");
    check("rst_async_idx", 32'(bus.step_idx), 0);
    check("rst_async_regwrite", 32'(bus.ctrl.regWrite), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkIdle("rst_release");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
